// File: rtl/ccsds123_frame_ctrl.sv
`default_nettype none
// ccsds123_frame_ctrl: gates the sample stream on image boundaries, tags each
// sample with BIP coordinates and bounds the number of images in flight.
module ccsds123_frame_ctrl #(
  parameter int D            = 16,
  parameter int NX           = 4,
  parameter int NY           = 2,
  parameter int NZ           = 3,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 16,
  localparam int XW = (NX > 1) ? $clog2(NX) : 1,
  localparam int YW = (NY > 1) ? $clog2(NY) : 1,
  localparam int ZW = (NZ > 1) ? $clog2(NZ) : 1,
  localparam int IW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic [D-1:0]     s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [D-1:0]     m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [XW-1:0]    m_x,
  output logic [YW-1:0]    m_y,
  output logic [ZW-1:0]    m_z,
  output logic             m_first,
  output logic             m_last,
  input  logic             out_tvalid,
  input  logic             out_tlast,
  output logic             busy,
  output logic [IW-1:0]    inflight,
  output logic [CNT_W-1:0] frames_done,
  output logic             err_tlast
);

  localparam logic [XW-1:0] XL   = XW'(NX - 1);
  localparam logic [YW-1:0] YL   = YW'(NY - 1);
  localparam logic [ZW-1:0] ZL   = ZW'(NZ - 1);
  localparam logic [IW-1:0] IMAX = IW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [ZW-1:0]    z_q, z_d;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             err_q, err_d;

  logic gate;
  logic hs;
  logic last_hs;
  logic done;

  // Zero-latency pass-through; only the handshake is gated.
  assign gate     = (state_q == ST_RUN);
  assign m_tdata  = s_tdata;
  assign m_tvalid = s_tvalid & gate;
  assign s_tready = m_tready & gate;
  assign hs       = m_tvalid & m_tready;

  assign m_x     = x_q;
  assign m_y     = y_q;
  assign m_z     = z_q;
  assign m_first = (x_q == '0) && (y_q == '0) && (z_q == '0);
  assign m_last  = (x_q == XL) && (y_q == YL) && (z_q == ZL);

  assign last_hs = hs & m_last;
  assign done    = out_tvalid & out_tlast;

  assign busy        = (state_q != ST_IDLE) || (inflight_q != '0);
  assign inflight    = inflight_q;
  assign frames_done = frames_q;
  assign err_tlast   = err_q;

  // BIP order: z fastest, then x, then y.
  always_comb begin
    z_d = z_q;
    x_d = x_q;
    y_d = y_q;
    if (hs) begin
      if (z_q == ZL) begin
        z_d = '0;
        if (x_q == XL) begin
          x_d = '0;
          y_d = (y_q == YL) ? '0 : y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end else begin
        z_d = z_q + ZW'(1);
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    frames_d   = frames_q;
    err_d      = err_q;
    if (done) begin
      if (last_hs) begin
        // Image enters and another leaves in the same cycle.
        frames_d = frames_q + CNT_W'(1);
      end else if (inflight_q != '0) begin
        inflight_d = inflight_q - IW'(1);
        frames_d   = frames_q + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (last_hs) begin
      inflight_d = inflight_q + IW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && (inflight_d < IMAX)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_hs) begin
          if (inflight_d == IMAX) state_d = ST_WAIT;
          else if (!enable)       state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (inflight_d < IMAX) state_d = enable ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      inflight_q <= '0;
      frames_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      inflight_q <= inflight_d;
      frames_q   <= frames_d;
      err_q      <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccsds123_frame_ctrl.sv
`default_nettype none
// Self-checking bench for ccsds123_frame_ctrl against an image-level model:
// sample index within the image, an in-flight count and an open/closed gate.
module tb_ccsds123_frame_ctrl;
  localparam int D     = 16;
  localparam int NX    = 4;
  localparam int NY    = 2;
  localparam int NZ    = 3;
  localparam int MAXI  = 2;
  localparam int CNT_W = 16;
  localparam int N     = NX * NY * NZ;
  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW = (NY > 1) ? $clog2(NY) : 1;
  localparam int ZW = (NZ > 1) ? $clog2(NZ) : 1;
  localparam int IW = $clog2(MAXI + 1);

  logic             clk;
  logic             aresetn;
  logic             enable;
  logic [D-1:0]     s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic [D-1:0]     m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic [XW-1:0]    m_x;
  logic [YW-1:0]    m_y;
  logic [ZW-1:0]    m_z;
  logic             m_first;
  logic             m_last;
  logic             out_tvalid;
  logic             out_tlast;
  logic             busy;
  logic [IW-1:0]    inflight;
  logic [CNT_W-1:0] frames_done;
  logic             err_tlast;

  ccsds123_frame_ctrl #(
    .D(D), .NX(NX), .NY(NY), .NZ(NZ), .MAX_INFLIGHT(MAXI), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_x(m_x), .m_y(m_y), .m_z(m_z), .m_first(m_first), .m_last(m_last),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .busy(busy), .inflight(inflight), .frames_done(frames_done),
    .err_tlast(err_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus requested for the next cycle.
  bit e_rst, e_en, e_sv, e_mr, e_done;

  // Reference model.
  int mk, minf, mfd, mhs;
  bit merr, mopen;
  int hs_seen;
  int guard;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic mdl_reset();
    mk = 0; minf = 0; mfd = 0; merr = 0; mopen = 0;
  endtask

  // One clock cycle: drive at negedge, check shortly after, then advance model.
  task automatic step();
    bit gate, hs, lst;
    int inf_n;
    @(negedge clk);
    aresetn    = e_rst;
    enable     = e_en;
    s_tvalid   = e_sv;
    m_tready   = e_mr;
    s_tdata    = D'($urandom);
    out_tlast  = e_done;
    out_tvalid = e_done | 1'($urandom);
    if (!e_rst) mdl_reset();
    #1;
    gate = e_rst && mopen;
    chk("s_tready",    32'(s_tready),    32'(e_mr & gate));
    chk("m_tvalid",    32'(m_tvalid),    32'(e_sv & gate));
    chk("m_tdata",     32'(m_tdata),     32'(s_tdata));
    chk("m_z",         32'(m_z),         32'(mk % NZ));
    chk("m_x",         32'(m_x),         32'((mk / NZ) % NX));
    chk("m_y",         32'(m_y),         32'(mk / (NZ * NX)));
    chk("m_first",     32'(m_first),     32'(mk == 0));
    chk("m_last",      32'(m_last),      32'(mk == N - 1));
    chk("inflight",    32'(inflight),    32'(minf));
    chk("frames_done", 32'(frames_done), 32'(mfd));
    chk("err_tlast",   32'(err_tlast),   32'(merr));
    chk("busy",        32'(busy),        32'(mopen || (minf != 0)));
    if (s_tvalid && s_tready) hs_seen++;
    if (e_rst) begin
      hs  = gate && e_sv && e_mr;
      lst = hs && (mk == N - 1);
      inf_n = minf + (lst ? 1 : 0);
      if (e_done) begin
        if (minf == 0 && !lst) merr = 1;
        else begin
          inf_n = inf_n - 1;
          mfd   = (mfd + 1) % (1 << CNT_W);
        end
      end
      mopen = mopen ? !(lst && (inf_n == MAXI || !e_en)) : (e_en && inf_n < MAXI);
      minf  = inf_n;
      if (hs) begin
        mk = (mk + 1) % N;
        mhs++;
      end
    end
    e_done = 0;
  endtask

  initial begin
    e_rst = 0; e_en = 0; e_sv = 0; e_mr = 0; e_done = 0;
    mhs = 0; hs_seen = 0;
    mdl_reset();
    repeat (3) step();

    // Back-to-back images until the in-flight limit closes the gate.
    e_rst = 1; e_en = 1; e_sv = 1; e_mr = 1;
    repeat (60) step();
    chk("wait_inflight", 32'(inflight), 32'(MAXI));
    chk("wait_tready",   32'(s_tready), 32'd0);

    // One completed bitstream reopens the gate a cycle later.
    e_done = 1; step();
    step();
    chk("reopen_tready", 32'(s_tready),    32'd1);
    chk("reopen_frames", 32'(frames_done), 32'd1);

    // out_tlast coincident with the final handshake at inflight==1.
    for (guard = 0; guard < 40; guard++) begin
      if (mk == N - 1 && mopen) begin
        e_done = 1; step();
        break;
      end
      step();
    end
    chk("coinc_bound", 32'(guard < 40), 32'd1);
    step();
    chk("b2b_tready",   32'(s_tready), 32'd1);
    chk("b2b_first",    32'(m_first),  32'd1);
    chk("b2b_inflight", 32'(inflight), 32'd1);
    chk("b2b_frames",   32'(frames_done), 32'd2);

    // Drain with enable low: current image finishes, then drain completions.
    e_en = 0;
    repeat (30) step();
    for (guard = 0; guard < 10 && minf > 0; guard++) begin
      e_done = 1; step();
    end
    step();
    chk("drain_busy", 32'(busy), 32'd0);

    // Enable dropped mid-image at sample 10.
    e_en = 1;
    for (guard = 0; guard < 40 && mk != 10; guard++) step();
    e_en = 0;
    repeat (20) step();
    chk("en_drop_tready",   32'(s_tready), 32'd0);
    chk("en_drop_inflight", 32'(inflight), 32'd1);
    e_en = 1;
    step();
    step();
    chk("restart_first",  32'(m_first),  32'd1);
    chk("restart_tready", 32'(s_tready), 32'd1);
    e_en = 0;
    repeat (30) step();
    for (guard = 0; guard < 10 && minf > 0; guard++) begin
      e_done = 1; step();
    end

    // Random valid/ready bubbles over two images.
    e_en = 1;
    mhs = 0; hs_seen = 0;
    for (guard = 0; guard < 2000 && mhs < 2 * N; guard++) begin
      e_sv = ($urandom_range(0, 2) != 0);
      e_mr = ($urandom_range(0, 2) != 0);
      step();
    end
    chk("bubble_bound", 32'(guard < 2000), 32'd1);
    chk("bubble_hs",    32'(hs_seen),      32'(2 * N));
    e_sv = 1; e_mr = 1;
    repeat (3) step();

    // Stray out_tlast while idle sets the sticky error.
    e_en = 0; e_rst = 0; step();
    e_rst = 1; step();
    e_done = 1; step();
    repeat (3) step();
    chk("err_sticky",   32'(err_tlast),   32'd1);
    chk("err_inflight", 32'(inflight),    32'd0);
    chk("err_frames",   32'(frames_done), 32'd0);

    // Asynchronous reset mid-frame at sample 7.
    e_en = 1;
    for (guard = 0; guard < 40 && mk != 7; guard++) step();
    e_rst = 0; step();
    chk("rst_err",    32'(err_tlast), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid),  32'd0);
    chk("rst_z",      32'(m_z),       32'd0);
    e_rst = 1;
    repeat (2) step();
    chk("rst_restart_first", 32'(m_first), 32'd1);
    repeat (30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccsds123_frame_ctrl.md
Name: ccsds123_frame_ctrl

Overview:
Frame sequencer between the sample source and the ccsds123_top input stream. It gates the input AXI-stream handshake on image boundaries and tags each sample with BIP coordinates (z fastest, then x, then y) plus first/last flags. It limits the number of images in flight inside the compressor by counting completed bitstreams (out_tvalid & out_tlast), and reports progress and protocol errors.

Parameters:
D, 16, sample width in bits
NX, 4, image width
NY, 2, image height
NZ, 3, number of bands
MAX_INFLIGHT, 2, maximum images accepted but not yet terminated by out_tlast (≥1)
CNT_W, 16, width of frames_done counter

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
enable  in  1  allow new images to start
s_tdata  in  D  sample from source
s_tvalid  in  1  source valid
s_tready  out  1  source ready
m_tdata  out  D  sample to compressor (in_tdata)
m_tvalid  out  1  to compressor in_tvalid
m_tready  in  1  from compressor in_tready
m_x  out  max(1,$clog2(NX))  x of current sample
m_y  out  max(1,$clog2(NY))  y of current sample
m_z  out  max(1,$clog2(NZ))  z of current sample
m_first  out  1  current sample is (0,0,0)
m_last  out  1  current sample is (NX-1,NY-1,NZ-1)
out_tvalid  in  1  compressor output valid (monitor only)
out_tlast  in  1  compressor output last (monitor only)
busy  out  1  state != IDLE or inflight != 0
inflight  out  $clog2(MAX_INFLIGHT+1)  images in flight
frames_done  out  CNT_W  completed bitstreams, wraps
err_tlast  out  1  sticky: out_tlast seen with inflight==0

Behaviour:
- Reset (async, aresetn=0): state=IDLE; x=y=z=0; inflight=0; frames_done=0; err_tlast=0. While in reset: s_tready=0, m_tvalid=0.
- Datapath combinational, zero latency: m_tdata=s_tdata; gate=(state==RUN); m_tvalid=s_tvalid&gate; s_tready=m_tready&gate. Handshake hs=m_tvalid&m_tready.
- m_x/m_y/m_z are registered counters; m_first/m_last are decoded combinationally from them.
- Counter advance on hs: z++; at z==NZ-1, z=0 and x++; at x==NX-1, x=0 and y++; at y==NY-1, y=0. All wrap to 0 together after the last sample.
- last_hs = hs & m_last. done = out_tvalid & out_tlast.
- inflight update: +1 on last_hs, -1 on done, net 0 if both in the same cycle. done with inflight==0 and no last_hs: inflight stays 0, err_tlast set. err_tlast clears only on reset.
- frames_done increments on every done that decrements inflight; wraps modulo 2^CNT_W.
- Let inflight_nxt be the post-update value. States:
  - IDLE: go to RUN when enable & inflight_nxt<MAX_INFLIGHT.
  - RUN: enable is ignored mid-frame. On last_hs: go to WAIT if inflight_nxt==MAX_INFLIGHT; else go to IDLE if !enable; else stay in RUN (back-to-back images, no bubble).
  - WAIT: when inflight_nxt<MAX_INFLIGHT, go to RUN if enable, else to IDLE.
- Transitions take effect at the next clock edge; gate is 0 for the whole cycle spent in IDLE or WAIT.
- Async reset mid-frame: coordinates and inflight are discarded; the next image starts at (0,0,0).

Test Plan:
- NX=4,NY=2,NZ=3, enable=1, continuous valid, m_tready=1 -> 24 handshakes. Coordinates: (0,0,0),(0,0,1),(0,0,2),(1,0,0)…; m_first only on the 1st, m_last only on the 24th; inflight goes 0->1 after the 24th.
- MAX_INFLIGHT=2, no out_tlast -> 48 samples accepted, then state=WAIT and s_tready=0. One out_tvalid&out_tlast pulse -> s_tready high one cycle later; inflight 2->1, frames_done=1.
- out_tlast coincident with the 24th handshake at inflight=1 -> inflight stays 1, frames_done +1, no gap before the next image's first sample.
- enable dropped at sample 10 -> image completes all 24 samples, then state=IDLE, s_tready=0. enable raised -> accepts again, m_first=1.
- Random m_tready and s_tvalid bubbles (1/3 duty) over 2 images -> coordinates advance only on hs; exactly 48 hs; m_tdata equals s_tdata on every hs.
- out_tlast pulse at reset-idle state -> err_tlast=1 (sticky), inflight=0, frames_done=0. Assert aresetn=0 mid-frame at sample 7 -> all outputs at reset values; restart begins at (0,0,0).
